// File: rtl/cpu_pkg.sv
// Shared types and constants for the writeback register file slice.
// Optional feature macro used by wb_reg_file: RF_BYPASS_EN.
package cpu_pkg;

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] word_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/wb_reg_file_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared on commit or flush, with two combinational busy lookups.
module wb_scoreboard #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          commit_en,
    input  logic [AW-1:0] commit_addr,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_addr,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic          rs_busy,
    output logic          rt_busy
);
    import cpu_pkg::*;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            iss_set;

    assign iss_set = iss_valid && (iss_addr != AW'(REG_ZERO));

    // Next busy vector: clear on commit first, then set on issue so a
    // younger producer to the same register keeps the mark.
    always_comb begin
        busy_d = busy_q;
        if (commit_en) begin
            busy_d[commit_addr] = 1'b0;
        end
        if (iss_set) begin
            busy_d[iss_addr] = 1'b1;
        end
    end

    // Busy register: reset and flush both clear every mark.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else if (flush) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign rs_busy = busy_q[rs_addr];
    assign rt_busy = busy_q[rt_addr];

    // A second writer may not be issued to a register still marked busy,
    // unless that register's commit lands in the same cycle.
    a_no_double_issue: assert property (@(posedge clk) disable iff (!rst_n)
        !(iss_set && !flush && busy_q[iss_addr] &&
          !(commit_en && (commit_addr == iss_addr))));

endmodule

// File: rtl/wb_reg_file.sv
// Writeback register file with pending-write scoreboard.
// Optional macro RF_BYPASS_EN: same-cycle write-to-read forwarding.
module wb_reg_file #(
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned DW   = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wb_regwrite,
    input  logic [AW-1:0] wb_rd_addr,
    input  logic [DW-1:0] wb_data,
    input  logic [AW-1:0] rs_addr,
    input  logic [AW-1:0] rt_addr,
    output logic [DW-1:0] rs_data,
    output logic [DW-1:0] rt_data,
    input  logic          iss_valid,
    input  logic [AW-1:0] iss_rd_addr,
    input  logic          flush,
    output logic          rs_busy,
    output logic          rt_busy
);
    import cpu_pkg::*;

    logic [DW-1:0] regs [NREG];
    logic          wr_en;
    logic          sb_rs_busy;
    logic          sb_rt_busy;

    assign wr_en = wb_regwrite && (wb_rd_addr != AW'(REG_ZERO));

    // Register storage: synchronous clear, r0 is never written so it stays 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wb_rd_addr] <= wb_data;
        end
    end

    wb_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .commit_en   (wb_regwrite),
        .commit_addr (wb_rd_addr),
        .iss_valid   (iss_valid),
        .iss_addr    (iss_rd_addr),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_busy     (sb_rs_busy),
        .rt_busy     (sb_rt_busy)
    );

`ifdef RF_BYPASS_EN
    logic rs_hit;
    logic rt_hit;

    // Read ports with forwarding: a matching in-flight write wins and
    // hides the busy mark it is about to clear.
    always_comb begin
        rs_hit  = wr_en && (rs_addr == wb_rd_addr);
        rt_hit  = wr_en && (rt_addr == wb_rd_addr);
        rs_data = rs_hit ? wb_data : regs[rs_addr];
        rt_data = rt_hit ? wb_data : regs[rt_addr];
        rs_busy = sb_rs_busy && !rs_hit;
        rt_busy = sb_rt_busy && !rt_hit;
    end
`else
    // Read ports: stored values and scoreboard marks only.
    always_comb begin
        rs_data = regs[rs_addr];
        rt_data = regs[rt_addr];
        rs_busy = sb_rs_busy;
        rt_busy = sb_rt_busy;
    end
`endif

endmodule
